// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the two-phase clock divider.
// Used by clock_divider and clkdiv_halfcnt.
package clkdiv_pkg;

    localparam int   CLKDIV_DEFAULT_RATIO = 2;
    localparam logic CLK1_RST             = 1'b0;

    // A ratio is legal when it is even and at least 2.
    function automatic logic ratio_ok(int r);
        return (r >= 2 && r % 2 == 0);
    endfunction

endpackage

// File: rtl/clkdiv_halfcnt.sv
// Modulo-HALF counter with async reset and a terminal pulse.
// tc is high during the cycle whose rising edge wraps the count.
module clkdiv_halfcnt
    import clkdiv_pkg::*;
#(
    parameter int HALF  = 1,
    parameter int CNT_W = $clog2(HALF) + 1
) (
    input  logic clk_in,
    input  logic rst,
    output logic tc
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: wrap at the terminal value, otherwise step by one.
    always_comb begin
        tc      = (count_q == TERM);
        count_d = count_q + 1'b1;
        if (tc) begin
            count_d = '0;
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clock_divider.sv
// Two-phase clock pair clk1/clk2 = clkIn / DIV_RATIO.
// Optional locked output when CLKDIV_LOCK_EN is defined.
module clock_divider
    import clkdiv_pkg::*;
#(
    parameter int DIV_RATIO = CLKDIV_DEFAULT_RATIO,
    parameter int CNT_W     = $clog2(DIV_RATIO / 2) + 1
) (
    input  logic clkIn,
    input  logic reset,
    output logic clk1,
    output logic clk2
`ifdef CLKDIV_LOCK_EN
    ,
    output logic locked
`endif
);

    if (!ratio_ok(DIV_RATIO)) begin : g_bad_ratio
        $error("clock_divider: DIV_RATIO must be even and >= 2");
    end

    logic tc;
    logic phase_q;
    logic phase_d;

    clkdiv_halfcnt #(
        .HALF  (DIV_RATIO / 2),
        .CNT_W (CNT_W)
    ) u_halfcnt (
        .clk_in (clkIn),
        .rst    (reset),
        .tc     (tc)
    );

    // Flip the phase at the end of every half-period.
    always_comb begin
        phase_d = phase_q ^ tc;
    end

    // Single phase flop; both outputs derive from it, so no skew.
    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            phase_q <= CLK1_RST;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign clk1 = phase_q;
    assign clk2 = ~phase_q;

`ifdef CLKDIV_LOCK_EN
    logic locked_q;
    logic locked_d;

    // Lock once clk1 falls for the first time (end of first period).
    always_comb begin
        locked_d = locked_q | (tc & phase_q);
    end

    // Sticky lock flag, cleared only by reset.
    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench: ratios 2, 4 and 6 share clkIn and reset.
// Expected toggles are pushed at each release; monitors pop them.
module tb_clock_divider;

    logic clkIn = 1'b0;
    logic reset = 1'b1;

    logic c1_a, c2_a;
    logic c1_b, c2_b;
    logic c1_c, c2_c;
`ifdef CLKDIV_LOCK_EN
    logic lk_a, lk_b, lk_c;
`endif

    int checks = 0;
    int errors = 0;
    int rel_edge = 0;

    int q_a[$];
    int q_b[$];
    int q_c[$];

    localparam int RAT_A = 2;
    localparam int RAT_B = 4;
    localparam int RAT_C = 6;

    always #15 clkIn = ~clkIn;

    clock_divider #(.DIV_RATIO(RAT_A)) dut_a (
        .clkIn  (clkIn),
        .reset  (reset),
        .clk1   (c1_a),
        .clk2   (c2_a)
`ifdef CLKDIV_LOCK_EN
        ,
        .locked (lk_a)
`endif
    );

    clock_divider #(.DIV_RATIO(RAT_B)) dut_b (
        .clkIn  (clkIn),
        .reset  (reset),
        .clk1   (c1_b),
        .clk2   (c2_b)
`ifdef CLKDIV_LOCK_EN
        ,
        .locked (lk_b)
`endif
    );

    clock_divider #(.DIV_RATIO(RAT_C)) dut_c (
        .clkIn  (clkIn),
        .reset  (reset),
        .clk1   (c1_c),
        .clk2   (c2_c)
`ifdef CLKDIV_LOCK_EN
        ,
        .locked (lk_c)
`endif
    );

    // Rising edges seen since the last reset release.
    always @(posedge clkIn) begin
        if (reset) rel_edge <= 0;
        else       rel_edge <= rel_edge + 1;
    end

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic push_exp(input int idx, input int v);
        case (idx)
            0:       q_a.push_back(v);
            1:       q_b.push_back(v);
            default: q_c.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int idx, output int v);
        case (idx)
            0:       v = q_a.pop_front();
            1:       v = q_b.pop_front();
            default: v = q_c.pop_front();
        endcase
    endtask

    // Model: within a run of k edges, clk1 flips every ratio/2 edges.
    task automatic plan(input int idx, input int ratio, input int k);
        int h;
        h = ratio / 2;
        for (int t = h; t <= k; t += h) begin
            push_exp(idx, t * 2 + ((t / h) % 2));
        end
    endtask

    task automatic on_event(input int idx, input logic a, input logic b);
        int e;
        int got;
        checks++;
        if (a !== ~b) begin
            errors++;
            $display("FAIL inv[%0d] clk1=%b clk2=%b", idx, a, b);
        end
        checks++;
        if (reset) begin
            if (a !== 1'b0) begin
                errors++;
                $display("FAIL rst_evt[%0d] clk1=%b want 0", idx, a);
            end
        end else if (qsize(idx) == 0) begin
            errors++;
            $display("FAIL extra[%0d] edge=%0d clk1=%b", idx, rel_edge, a);
        end else begin
            pop_exp(idx, e);
            got = rel_edge * 2 + int'(a);
            if (got != e) begin
                errors++;
                $display("FAIL toggle[%0d] edge=%0d v=%0d want edge=%0d v=%0d",
                         idx, got / 2, got % 2, e / 2, e % 2);
            end
        end
    endtask

    always @(c1_a) begin #1; on_event(0, c1_a, c2_a); end
    always @(c1_b) begin #1; on_event(1, c1_b, c2_b); end
    always @(c1_c) begin #1; on_event(2, c1_c, c2_c); end

    task automatic chk_rst(input string nm);
        checks++;
        if ({c1_a, c1_b, c1_c} !== 3'b000 ||
            {c2_a, c2_b, c2_c} !== 3'b111) begin
            errors++;
            $display("FAIL %s clk1=%b%b%b want 000 clk2=%b%b%b want 111",
                     nm, c1_a, c1_b, c1_c, c2_a, c2_b, c2_c);
        end
`ifdef CLKDIV_LOCK_EN
        checks++;
        if ({lk_a, lk_b, lk_c} !== 3'b000) begin
            errors++;
            $display("FAIL %s_lock got=%b%b%b want 000",
                     nm, lk_a, lk_b, lk_c);
        end
`endif
    endtask

`ifdef CLKDIV_LOCK_EN
    task automatic chk_lock(input int n);
        logic [2:0] w;
        w = {n >= RAT_A, n >= RAT_B, n >= RAT_C};
        checks++;
        if ({lk_a, lk_b, lk_c} !== w) begin
            errors++;
            $display("FAIL lock edge=%0d got=%b%b%b want %b",
                     n, lk_a, lk_b, lk_c, w);
        end
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        for (int r = 0; r < 8; r++) begin
            repeat (3) begin
                @(negedge clkIn);
                chk_rst("rst_hold");
            end
            k = (r == 0) ? 100 : $urandom_range(4, 40);
            plan(0, RAT_A, k);
            plan(1, RAT_B, k);
            plan(2, RAT_C, k);
            reset = 1'b0;
            for (int i = 1; i <= k; i++) begin
                @(negedge clkIn);
`ifdef CLKDIV_LOCK_EN
                chk_lock(i);
`endif
            end
            #($urandom_range(1, 12));
            reset = 1'b1;
            #1;
            chk_rst("rst_async");
            checks++;
            if (qsize(0) + qsize(1) + qsize(2) != 0) begin
                errors++;
                $display("FAIL missing run=%0d left=%0d want 0",
                         r, qsize(0) + qsize(1) + qsize(2));
            end
        end
        @(negedge clkIn);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
